// File: rtl/trap_sequencer.sv
// Trap sequencer: arbitrates trap, return and wait events, sequences the trap CSR
// update, and hands a redirect target to fetch over a valid/ready handshake.
module trap_sequencer #(
  parameter int XLEN        = 64,
  parameter int WFI_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            IllegalInstrFaultM,
  input  logic            EcallFaultM,
  input  logic            BreakpointFaultM,
  input  logic            mretM,
  input  logic            wfiM,
  input  logic            InterruptPendingM,
  input  logic [3:0]      IntCauseM,
  input  logic [XLEN-1:0] PCM,
  input  logic [XLEN-1:0] MTVEC_REGW,
  input  logic [XLEN-1:0] MEPC_REGW,
  input  logic [1:0]      PrivilegeModeW,
  input  logic            WfiTrapEn,
  output logic            RedirectValid,
  output logic [XLEN-1:0] RedirectPC,
  input  logic            RedirectReady,
  output logic            CSRWriteM,
  output logic [XLEN-1:0] MEPCWrite,
  output logic [XLEN-1:0] MCAUSEWrite,
  output logic            Busy,
  output logic            Sleeping
);

  localparam int              CW       = $clog2(WFI_TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WFI_TIMEOUT - 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(WFI_TIMEOUT);
  localparam logic [XLEN-1:0] FOUR     = XLEN'(4);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SAVE     = 2'd1,
    REDIRECT = 2'd2,
    SLEEP    = 2'd3
  } state_t;

  state_t          state_r, next_s;
  logic [XLEN-1:0] epc_r, epcNext_s;
  logic [XLEN-1:0] cause_r, causeNext_s;
  logic [XLEN-1:0] targetNext_s, trapBase_s, trapTarget_s;
  logic [CW-1:0]   cnt_r, cntNext_s;

  function automatic logic [XLEN-1:0] intCause(input logic [3:0] code);
    logic [XLEN-1:0] c;
    c           = '0;
    c[XLEN-1]   = 1'b1;
    c[3:0]      = code;
    return c;
  endfunction

  // Trap vector: vectored mode only offsets interrupt causes
  always_comb begin
    trapBase_s = {MTVEC_REGW[XLEN-1:2], 2'b00};
    if ((MTVEC_REGW[1:0] == 2'b01) && cause_r[XLEN-1]) begin
      trapTarget_s = trapBase_s + {{(XLEN-6){1'b0}}, cause_r[3:0], 2'b00};
    end else begin
      trapTarget_s = trapBase_s;
    end
  end

  // Next-state, captured EPC/cause, wait counter and redirect target
  always_comb begin
    next_s       = state_r;
    epcNext_s    = epc_r;
    causeNext_s  = cause_r;
    cntNext_s    = cnt_r;
    targetNext_s = RedirectPC;
    case (state_r)
      IDLE: begin
        if (InterruptPendingM) begin
          next_s      = SAVE;
          epcNext_s   = PCM;
          causeNext_s = intCause(IntCauseM);
        end else if (BreakpointFaultM) begin
          next_s      = SAVE;
          epcNext_s   = PCM;
          causeNext_s = XLEN'(4'd3);
        end else if (EcallFaultM) begin
          next_s      = SAVE;
          epcNext_s   = PCM;
          causeNext_s = XLEN'(4'd8 + {2'b00, PrivilegeModeW});
        end else if (IllegalInstrFaultM) begin
          next_s      = SAVE;
          epcNext_s   = PCM;
          causeNext_s = XLEN'(4'd2);
        end else if (mretM) begin
          next_s       = REDIRECT;
          targetNext_s = MEPC_REGW;
        end else if (wfiM) begin
          next_s    = SLEEP;
          epcNext_s = PCM + FOUR;
          cntNext_s = '0;
        end else begin
          next_s = IDLE;
        end
      end
      SAVE: begin
        next_s       = REDIRECT;
        targetNext_s = trapTarget_s;
      end
      REDIRECT: begin
        if (RedirectReady) begin
          next_s = IDLE;
        end else begin
          next_s = REDIRECT;
        end
      end
      SLEEP: begin
        // Saturate rather than wrap so an untimed wait never re-arms the timeout
        if (cnt_r == CNT_MAX) begin
          cntNext_s = cnt_r;
        end else begin
          cntNext_s = cnt_r + 1'b1;
        end
        if (InterruptPendingM) begin
          next_s      = SAVE;
          causeNext_s = intCause(IntCauseM);
        end else if (WfiTrapEn && (cnt_r >= CNT_LAST)) begin
          next_s      = SAVE;
          causeNext_s = XLEN'(4'd2);
          epcNext_s   = epc_r - FOUR;
        end else begin
          next_s = SLEEP;
        end
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // State and registered outputs, decoded from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      epc_r         <= '0;
      cause_r       <= '0;
      cnt_r         <= '0;
      CSRWriteM     <= 1'b0;
      MEPCWrite     <= '0;
      MCAUSEWrite   <= '0;
      RedirectValid <= 1'b0;
      RedirectPC    <= '0;
      Busy          <= 1'b0;
      Sleeping      <= 1'b0;
    end else begin
      state_r       <= next_s;
      epc_r         <= epcNext_s;
      cause_r       <= causeNext_s;
      cnt_r         <= cntNext_s;
      CSRWriteM     <= (next_s == SAVE);
      MEPCWrite     <= (next_s == SAVE) ? epcNext_s : '0;
      MCAUSEWrite   <= (next_s == SAVE) ? causeNext_s : '0;
      RedirectValid <= (next_s == REDIRECT);
      RedirectPC    <= (next_s == REDIRECT) ? targetNext_s : '0;
      Busy          <= (next_s != IDLE);
      Sleeping      <= (next_s == SLEEP);
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed self-checking bench for trap_sequencer with hand-computed expectations.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        IllegalInstrFaultM, EcallFaultM, BreakpointFaultM, mretM, wfiM;
  logic        InterruptPendingM;
  logic [3:0]  IntCauseM;
  logic [63:0] PCM, MTVEC_REGW, MEPC_REGW;
  logic [1:0]  PrivilegeModeW;
  logic        WfiTrapEn;
  logic        RedirectValid;
  logic [63:0] RedirectPC;
  logic        RedirectReady;
  logic        CSRWriteM;
  logic [63:0] MEPCWrite, MCAUSEWrite;
  logic        Busy, Sleeping;

  int passCnt  = 0;
  int totalCnt = 0;
  logic [63:0] heldPC;

  trap_sequencer dut (
    .clk(clk), .reset(reset),
    .IllegalInstrFaultM(IllegalInstrFaultM), .EcallFaultM(EcallFaultM),
    .BreakpointFaultM(BreakpointFaultM), .mretM(mretM), .wfiM(wfiM),
    .InterruptPendingM(InterruptPendingM), .IntCauseM(IntCauseM),
    .PCM(PCM), .MTVEC_REGW(MTVEC_REGW), .MEPC_REGW(MEPC_REGW),
    .PrivilegeModeW(PrivilegeModeW), .WfiTrapEn(WfiTrapEn),
    .RedirectValid(RedirectValid), .RedirectPC(RedirectPC), .RedirectReady(RedirectReady),
    .CSRWriteM(CSRWriteM), .MEPCWrite(MEPCWrite), .MCAUSEWrite(MCAUSEWrite),
    .Busy(Busy), .Sleeping(Sleeping)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearEvents();
    IllegalInstrFaultM = 1'b0; EcallFaultM = 1'b0; BreakpointFaultM = 1'b0;
    mretM = 1'b0; wfiM = 1'b0; InterruptPendingM = 1'b0;
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, ".Busy"}, 64'(Busy), 64'd0);
    chk({tag, ".CSRWriteM"}, 64'(CSRWriteM), 64'd0);
    chk({tag, ".RedirectValid"}, 64'(RedirectValid), 64'd0);
    chk({tag, ".Sleeping"}, 64'(Sleeping), 64'd0);
    chk({tag, ".RedirectPC"}, RedirectPC, 64'd0);
    chk({tag, ".MEPCWrite"}, MEPCWrite, 64'd0);
    chk({tag, ".MCAUSEWrite"}, MCAUSEWrite, 64'd0);
  endtask

  task automatic chkSave(input string tag, input logic [63:0] epc, input logic [63:0] cause);
    chk({tag, ".CSRWriteM"}, 64'(CSRWriteM), 64'd1);
    chk({tag, ".MEPCWrite"}, MEPCWrite, epc);
    chk({tag, ".MCAUSEWrite"}, MCAUSEWrite, cause);
    chk({tag, ".RedirectValid"}, 64'(RedirectValid), 64'd0);
  endtask

  task automatic chkRedirect(input string tag, input logic [63:0] pc);
    chk({tag, ".RedirectValid"}, 64'(RedirectValid), 64'd1);
    chk({tag, ".RedirectPC"}, RedirectPC, pc);
    chk({tag, ".CSRWriteM"}, 64'(CSRWriteM), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    clearEvents();
    IntCauseM = 4'd0; PCM = 64'd0; MTVEC_REGW = 64'h8000_0001; MEPC_REGW = 64'd0;
    PrivilegeModeW = 2'd0; WfiTrapEn = 1'b1; RedirectReady = 1'b0;
    tick(); tick();
    chkAllZero("reset");

    // Ecall from U right after reset release
    reset = 1'b0; EcallFaultM = 1'b1; PCM = 64'h1000;
    tick(); clearEvents();
    chkSave("ecallU", 64'h1000, 64'd8);
    tick();
    chkRedirect("ecallU", 64'h8000_0000);
    RedirectReady = 1'b1;
    tick(); RedirectReady = 1'b0;
    chkAllZero("ecallU.idle");

    // Ecall from M gives cause 11
    EcallFaultM = 1'b1; PrivilegeModeW = 2'd3; PCM = 64'h1100;
    tick(); clearEvents(); PrivilegeModeW = 2'd0;
    chkSave("ecallM", 64'h1100, 64'd11);
    RedirectReady = 1'b1; tick(); tick(); RedirectReady = 1'b0;
    chk("ecallM.idle", 64'(Busy), 64'd0);

    // Vectored interrupt beats a simultaneous ecall
    InterruptPendingM = 1'b1; IntCauseM = 4'd7; EcallFaultM = 1'b1; PCM = 64'h2000;
    tick(); clearEvents();
    chkSave("vecInt", 64'h2000, 64'h8000_0000_0000_0007);
    tick();
    chkRedirect("vecInt", 64'h8000_001C);
    RedirectReady = 1'b1; tick(); RedirectReady = 1'b0;
    chk("vecInt.idle", 64'(Busy), 64'd0);

    // Breakpoint + illegal + mret: breakpoint only, redirect held under backpressure
    BreakpointFaultM = 1'b1; IllegalInstrFaultM = 1'b1; mretM = 1'b1;
    PCM = 64'h2400; MEPC_REGW = 64'h5555;
    tick(); clearEvents();
    chkSave("brk", 64'h2400, 64'd3);
    tick();
    chkRedirect("brk", 64'h8000_0000);
    heldPC = 64'h8000_0000;
    EcallFaultM = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("brk.holdValid", 64'(RedirectValid), 64'd1);
      chk("brk.holdPC", RedirectPC, heldPC);
    end
    EcallFaultM = 1'b0; RedirectReady = 1'b1;
    tick(); RedirectReady = 1'b0;
    chk("brk.idle", 64'(Busy), 64'd0);
    tick();
    chk("busyIgnored", 64'(Busy), 64'd0);

    // WFI timeout trap after exactly WFI_TIMEOUT sleep cycles
    wfiM = 1'b1; PCM = 64'h3000; WfiTrapEn = 1'b1;
    tick(); clearEvents();
    chk("wfiTo.sleep1", 64'(Sleeping), 64'd1);
    chk("wfiTo.busy", 64'(Busy), 64'd1);
    for (int i = 2; i <= 16; i++) begin
      tick();
      chk("wfiTo.sleepN", 64'(Sleeping), 64'd1);
    end
    tick();
    chk("wfiTo.woke", 64'(Sleeping), 64'd0);
    chkSave("wfiTo", 64'h3000, 64'd2);
    tick();
    chkRedirect("wfiTo", 64'h8000_0000);
    RedirectReady = 1'b1; tick(); RedirectReady = 1'b0;

    // WFI woken by interrupt on sleep cycle 4, then mret back
    wfiM = 1'b1; PCM = 64'h3000;
    tick(); clearEvents();
    tick(); tick(); tick();
    chk("wfiInt.sleep4", 64'(Sleeping), 64'd1);
    InterruptPendingM = 1'b1; IntCauseM = 4'd11;
    tick(); clearEvents();
    chkSave("wfiInt", 64'h3004, 64'h8000_0000_0000_000B);
    tick();
    chkRedirect("wfiInt", 64'h8000_002C);
    RedirectReady = 1'b1; tick(); RedirectReady = 1'b0;
    mretM = 1'b1; MEPC_REGW = 64'h3004;
    tick(); clearEvents();
    chkRedirect("mret", 64'h3004);
    chk("mret.mcause", MCAUSEWrite, 64'd0);
    RedirectReady = 1'b1; tick(); RedirectReady = 1'b0;
    chk("mret.idle", 64'(Busy), 64'd0);

    // wfi coincident with interrupt takes the interrupt at PCM
    wfiM = 1'b1; InterruptPendingM = 1'b1; IntCauseM = 4'd3; PCM = 64'h4000;
    tick(); clearEvents();
    chk("wfiCoinc.sleep", 64'(Sleeping), 64'd0);
    chkSave("wfiCoinc", 64'h4000, 64'h8000_0000_0000_0003);
    RedirectReady = 1'b1; tick(); tick(); RedirectReady = 1'b0;

    // Untimed WFI never traps; reset in SLEEP clears immediately
    WfiTrapEn = 1'b0; wfiM = 1'b1; PCM = 64'h5000;
    tick(); clearEvents();
    for (int i = 0; i < 40; i++) tick();
    chk("wfiForever.sleep", 64'(Sleeping), 64'd1);
    chk("wfiForever.noSave", 64'(CSRWriteM), 64'd0);
    reset = 1'b1; #1;
    chkAllZero("rstSleep");
    tick();
    reset = 1'b0; EcallFaultM = 1'b1; PCM = 64'h6000;
    tick(); clearEvents();
    chkSave("postRstSleep", 64'h6000, 64'd8);
    tick();
    chkRedirect("preRstRedir", 64'h8000_0000);

    // Reset in REDIRECT, then a normal ecall
    reset = 1'b1; #1;
    chkAllZero("rstRedir");
    tick();
    reset = 1'b0; EcallFaultM = 1'b1; PrivilegeModeW = 2'd1; PCM = 64'h7000;
    tick(); clearEvents();
    chkSave("postRstRedir", 64'h7000, 64'd9);
    tick();
    chkRedirect("postRstRedir", 64'h8000_0000);
    RedirectReady = 1'b1; tick(); RedirectReady = 1'b0;
    chk("final.idle", 64'(Busy), 64'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width.
REQ-002 SHALL have parameter WFI_TIMEOUT, default 16, number of SLEEP cycles before a WFI timeout trap (>=1).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports IllegalInstrFaultM, EcallFaultM, BreakpointFaultM, mretM, wfiM  input  1 each  decoded trap/return/wait events.
REQ-006 SHALL have ports InterruptPendingM  input  1  and IntCauseM  input  4  enabled interrupt pending and its cause code.
REQ-007 SHALL have ports PCM  input  XLEN  PC of the event instruction; MTVEC_REGW, MEPC_REGW  input  XLEN each  trap vector and return address.
REQ-008 SHALL have ports PrivilegeModeW  input  2  current mode; WfiTrapEn  input  1  enables the WFI timeout trap.
REQ-009 SHALL have ports RedirectValid  output  1, RedirectPC  output  XLEN, RedirectReady  input  1  fetch redirect handshake.
REQ-010 SHALL have ports CSRWriteM  output  1, MEPCWrite  output  XLEN, MCAUSEWrite  output  XLEN  trap CSR update.
REQ-011 SHALL have ports Busy  output  1  (state != IDLE) and Sleeping  output  1  (state == SLEEP).

Function
REQ-012 SHALL implement states IDLE, SAVE, REDIRECT, SLEEP.
REQ-013 In IDLE, SHALL accept at most one event per cycle, priority: interrupt > breakpoint > ecall > illegal > mret > wfi; lower-priority simultaneous events are dropped.
REQ-014 Cause codes: interrupt = MSB set, IntCauseM in bits [3:0]; breakpoint = 3; illegal = 2; ecall = 8 + PrivilegeModeW (8 U, 9 S, 11 M).
REQ-015 On an interrupt or fault in IDLE, SHALL capture EPC = PCM and cause, then go to SAVE.
REQ-016 SAVE SHALL last exactly one cycle, assert CSRWriteM with MEPCWrite = EPC and MCAUSEWrite = cause, then go to REDIRECT.
REQ-017 Trap target: base = {MTVEC_REGW[XLEN-1:2], 2'b00}. If MTVEC_REGW[1:0] == 01 and the cause is an interrupt, target = base + 4*IntCauseM; otherwise target = base. Arithmetic is modulo 2^XLEN.
REQ-018 On mretM in IDLE, SHALL go directly to REDIRECT with target = MEPC_REGW and no CSR write.
REQ-019 In REDIRECT, SHALL assert RedirectValid with RedirectPC stable until RedirectReady is sampled high, then return to IDLE the following cycle.
REQ-020 On wfiM in IDLE, SHALL go to SLEEP, clear the timeout counter and capture EPC = PCM + 4 (mod 2^XLEN).
REQ-021 In SLEEP, the counter SHALL increment each cycle; InterruptPendingM SHALL go to SAVE with the interrupt cause and EPC = PCM+4 as captured.
REQ-022 In SLEEP with WfiTrapEn high, on the WFI_TIMEOUT-th SLEEP cycle SHALL go to SAVE with cause 2 and EPC = wfi PC (PCM+4 - 4). An interrupt in the same cycle wins.
REQ-023 In SLEEP with WfiTrapEn low, SHALL wait indefinitely; the counter saturates and does not wrap.
REQ-024 Events presented while Busy SHALL be ignored; upstream stalls on Busy.
REQ-025 wfiM coincident with InterruptPendingM in IDLE SHALL take the interrupt with EPC = PCM (SLEEP never entered).
REQ-026 CSRWriteM SHALL be high only in SAVE; RedirectValid only in REDIRECT; Sleeping only in SLEEP.

Reset
REQ-027 On reset assertion, SHALL enter IDLE immediately regardless of state, including mid-SAVE, REDIRECT or SLEEP.
REQ-028 During reset, every output SHALL be 0 (RedirectPC, MEPCWrite, MCAUSEWrite all zero) and the counter SHALL be cleared.
REQ-029 After reset deassertion, the first event SHALL be accepted on the next rising edge.

Verification
REQ-030 Ecall from U: PCM=0x1000, MTVEC=0x8000_0001 -> SAVE with MEPCWrite=0x1000, MCAUSEWrite=8; RedirectPC=0x8000_0000.
REQ-031 Vectored interrupt: IntCauseM=7, MTVEC=0x8000_0001, PCM=0x2000 -> MCAUSEWrite=0x8000_0000_0000_0007, RedirectPC=0x8000_001C.
REQ-032 Breakpoint + illegal + mret together -> cause 3 only; RedirectReady held low 5 cycles -> RedirectValid and RedirectPC stable throughout.
REQ-033 wfi at PCM=0x3000, WfiTrapEn=1, WFI_TIMEOUT=16, no interrupt -> Sleeping 16 cycles, then MCAUSEWrite=2, MEPCWrite=0x3000.
REQ-034 wfi at PCM=0x3000, interrupt cause 11 on SLEEP cycle 4 -> MEPCWrite=0x3004, MCAUSEWrite=MSB|11; mret at MEPC=0x3004 -> RedirectPC=0x3004, CSRWriteM never high.
REQ-035 Reset asserted in REDIRECT and in SLEEP -> all outputs 0 at once, Busy=0; next ecall handled normally.
